// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath: operand width, exponentiator
// FSM states and the handshake timing of the serial modular multiplier.
package rsa_pkg;

    localparam int WIDTH_DEF = 512;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        MUL,
        STEP,
        DONE
    } state_e;

    // Level of the go strobe that loads a new multiplication.
    localparam logic MM_GO_ACTIVE = 1'b1;

    // Cycles from the go strobe to the rdy pulse: one multiplier bit per cycle.
    function automatic int mm_latency(input int width);
        return width;
    endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// Interleaved shift-add modular multiplier, p = a*b mod n, MSB-first over a.
// The first bit is consumed on the go edge, so rdy pulses exactly
// mm_latency(WIDTH) cycles after go and p then holds until the next go.
module mod_mul_serial
    import rsa_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] p,
    output logic             rdy
);

    localparam int AW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] n_q;
    logic [AW-1:0]    acc_q;
    logic [CW-1:0]    cnt_q;
    logic             rdy_q;

    // One interleaved step: acc < n keeps 2*acc + b below 3n, so two
    // conditional subtracts always bring the partial product back under n.
    function automatic logic [AW-1:0] mm_step(input logic [AW-1:0]    acc,
                                              input logic             a_bit,
                                              input logic [WIDTH-1:0] bv,
                                              input logic [WIDTH-1:0] nv);
        logic [AW-1:0] t;
        logic [AW-1:0] nn;
        nn = {2'b00, nv};
        t  = {acc[AW-2:0], 1'b0} + (a_bit ? {2'b00, bv} : '0);
        if (t >= nn) t = t - nn;
        if (t >= nn) t = t - nn;
        return t;
    endfunction

    // Load on go, then walk the remaining multiplier bits one per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            if (go == MM_GO_ACTIVE) begin
                acc_q <= mm_step('0, a[WIDTH-1], b, n);
                a_q   <= a << 1;
                b_q   <= b;
                n_q   <= n;
                cnt_q <= CW'(mm_latency(WIDTH) - 1);
            end else if (cnt_q != '0) begin
                acc_q <= mm_step(acc_q, a_q[WIDTH-1], b_q, n_q);
                a_q   <= a_q << 1;
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) rdy_q <= 1'b1;
            end
        end
    end

    assign p   = acc_q[WIDTH-1:0];
    assign rdy = rdy_q;

endmodule

// File: rtl/mod_exp_engine.sv
// RSA modular exponentiator, result = base^exp mod modulus, using
// right-to-left square-and-multiply with two serial multipliers running
// the multiply (acc*sq) and the square (sq*sq) of each exponent bit together.
module mod_exp_engine
    import rsa_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             err
);

    state_e           state_q;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] e_sh_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] sq_q;
    logic [WIDTH-1:0] result_q;
    logic             done_q;
    logic             busy_q;
    logic             err_q;

    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] sq_d;
    logic [WIDTH-1:0] e_sh_d;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] p_w;
    logic [WIDTH-1:0] s_w;
    logic             p_rdy;
    logic             s_rdy;
    logic             operands_bad;
    logic             go_d;

    // STEP's next values, and a multiplier launch from CHECK or STEP fed with
    // the operands the following MUL phase will work on.
    always_comb begin
        acc_d        = e_sh_q[0] ? p_w : acc_q;
        sq_d         = s_w;
        e_sh_d       = e_sh_q >> 1;
        operands_bad = (n_q < WIDTH'(2)) || (sq_q >= n_q);
        go_d         = 1'b0;
        mul_a        = acc_q;
        mul_b        = sq_q;
        if (state_q == CHECK) begin
            go_d = !operands_bad && (e_sh_q != '0);
        end else if (state_q == STEP) begin
            go_d  = (e_sh_d != '0);
            mul_a = acc_d;
            mul_b = sq_d;
        end
    end

    mod_mul_serial #(.WIDTH(WIDTH)) u_mul_p (
        .clk (clk),
        .rst (rst),
        .go  (go_d),
        .a   (mul_a),
        .b   (mul_b),
        .n   (n_q),
        .p   (p_w),
        .rdy (p_rdy)
    );

    mod_mul_serial #(.WIDTH(WIDTH)) u_mul_s (
        .clk (clk),
        .rst (rst),
        .go  (go_d),
        .a   (mul_b),
        .b   (mul_b),
        .n   (n_q),
        .p   (s_w),
        .rdy (s_rdy)
    );

    // Control FSM with registered result/done/busy/err; the exponent is
    // consumed LSB-first and the loop ends as soon as no set bits remain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        sq_q    <= base;
                        n_q     <= modulus;
                        e_sh_q  <= exp;
                        acc_q   <= WIDTH'(1);
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (operands_bad) begin
                        err_q    <= 1'b1;
                        result_q <= '0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else if (e_sh_q == '0) begin
                        result_q <= WIDTH'(1);
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    if (p_rdy && s_rdy) state_q <= STEP;
                end
                STEP: begin
                    acc_q  <= acc_d;
                    sq_q   <= sq_d;
                    e_sh_q <= e_sh_d;
                    if (e_sh_d == '0) begin
                        result_q <= acc_d;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        state_q <= MUL;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign err    = err_q;

endmodule
